pc_target_unit: RTL and testbench
=================================

Name: pc_target_unit

Overview:
- Parametrised program-counter and next-target unit for the CSE141 core.
- Holds the PC register and selects the next PC from four sources:
  - sequential
  - PC-relative offset
  - absolute lookup-table entry
  - return address
- Adds a small return-address stack (RAS) so absolute jumps can act as calls and later return.
- Sits between the decoder/branch-condition logic and instruction-memory address input.

Parameters:
- D, 12, PC/target width in bits; all PC arithmetic is modulo 2^D.
- RAS_DEPTH, 4, number of return-address stack entries (≥1).
- START, 0, PC value loaded on reset (D bits).
- PROG_LEN, 4096, number of valid instruction addresses (used only with the optional feature).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset (Reset=0 at a rising Clk edge resets the block).
- stall  in  1  1 = hold PC and stack this cycle.
- jump_mode  in  2  next-PC source: 00 sequential, 01 relative, 10 absolute, 11 return.
- branch_take  in  1  condition result; gates modes 01/10/11.
- offset_target  in  D  signed two's-complement offset for mode 01.
- entry_target  in  D  absolute target from the lookup table for mode 10.
- call_en  in  1  with mode 10 taken: push PC+1 onto the RAS.
- prog_counter  out  D  current PC (register output).
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_count  out  $clog2(RAS_DEPTH+1)  current RAS occupancy.
- ras_err  out  1  sticky overflow/underflow flag.

Behaviour:
Reset (Reset=0 at posedge):
- prog_counter=START, ras_count=0, ras_empty=1, ras_full=0, ras_err=0.
- All RAS entries cleared to 0.
- Reset overrides stall and every other input, including mid-call or mid-return.

Next-PC selection (combinational, registered at posedge when Reset=1 and stall=0):
- Mode 00, or branch_take=0 in any mode: PC+1.
- Mode 01 taken: PC + sign-extended offset_target.
- Mode 10 taken: entry_target.
- Mode 11 taken: top of RAS.
- All adds are truncated to D bits, so wrap-around is legal: PC=2^D-1 with mode 00 gives 0.

Latency:
- New PC is visible on prog_counter one cycle after the selecting inputs.
- No combinational path from inputs to prog_counter.

Stall:
- PC, RAS contents, ras_count and ras_err all hold.
- call_en and mode 11 have no effect.

Push (mode 10 taken, call_en=1, stall=0):
- If not full: write PC+1 (modulo 2^D) at index ras_count, ras_count+1.
- If full: push dropped, ras_err←1, stack unchanged, jump still taken.

Pop (mode 11 taken, stall=0):
- If not empty: PC←entry[ras_count-1], ras_count−1.
- If empty: ras_err←1, PC←PC+1.

Other rules:
- call_en with any mode other than 10-taken is ignored.
- Push and pop can never occur in the same cycle, since modes are exclusive.
- ras_err stays set until reset.
- ras_empty and ras_full are decoded combinationally from the registered ras_count.

Optional Feature:
Macro PC_BOUNDS_CHECK_EN.
- When defined:
  - Extra output pc_oob (1 bit, reset 0) is registered high for one cycle whenever the next PC about to be loaded is ≥ PROG_LEN.
  - That PC is replaced by START; the RAS is unaffected.
- When undefined:
  - No pc_oob port.
  - Every next PC is loaded unchanged, including values ≥ PROG_LEN.

Test Plan:
1. Reset=0 for 2 cycles with START=5, then mode 00 for 3 cycles → prog_counter 5,6,7,8; ras_empty=1, ras_err=0.
2. PC=10, mode 01, branch_take=1, offset_target=12'hFFB (−5) → PC=5 next cycle. Same setup with branch_take=0 → PC=11.
3. PC=20, mode 10, call_en=1, entry_target=100, taken → PC=100, ras_count=1. Then mode 11 taken → PC=21, ras_empty=1.
4. Five nested calls with RAS_DEPTH=4 → ras_full after the 4th call; 5th jump still lands on entry_target with ras_err=1 and ras_count=4. Four returns then pop the addresses in LIFO order.
5. Mode 11 taken while empty at PC=30 → PC=31, ras_err=1. ras_err stays 1 through 10 further cycles and clears only on Reset=0.
6. stall=1 for 3 cycles while mode 10/call_en asserted at PC=40 → PC stays 40, ras_count unchanged. PC=12'hFFF with mode 00 → 0. Reset=0 asserted together with stall=1 → PC=START.

Source files
------------

// File: rtl/pc_target_unit.sv
// PC register and next-target select with a small return-address stack.
// Optional PC_BOUNDS_CHECK_EN: redirect out-of-program PCs to START, flag pc_oob.
module pc_target_unit #(
    parameter int             D         = 12,
    parameter int             RAS_DEPTH = 4,
    parameter logic [D-1:0]   START     = '0,
    parameter int             PROG_LEN  = 4096,
    localparam int            CW        = $clog2(RAS_DEPTH + 1),
    localparam int            IW        = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          stall,
    input  logic [1:0]    jump_mode,
    input  logic          branch_take,
    input  logic [D-1:0]  offset_target,
    input  logic [D-1:0]  entry_target,
    input  logic          call_en,
    output logic [D-1:0]  prog_counter,
    output logic          ras_empty,
    output logic          ras_full,
    output logic [CW-1:0] ras_count,
    output logic          ras_err
`ifdef PC_BOUNDS_CHECK_EN
    ,
    output logic          pc_oob
`endif
);

    logic [D-1:0]  ras [RAS_DEPTH];
    logic [D-1:0]  pc_inc;
    logic [D-1:0]  next_pc;
    logic [D-1:0]  pc_load;
    logic [CW-1:0] top_cnt;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] push_idx;
    logic          take_rel;
    logic          take_abs;
    logic          take_ret;
    logic          push_ok;
    logic          pop_ok;
    logic          ras_fault;

    assign pc_inc    = prog_counter + D'(1);
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CW'(RAS_DEPTH));
    assign top_cnt   = ras_count - CW'(1);
    assign top_idx   = top_cnt[IW-1:0];
    assign push_idx  = ras_count[IW-1:0];

    assign take_rel = branch_take && (jump_mode == 2'b01);
    assign take_abs = branch_take && (jump_mode == 2'b10);
    assign take_ret = branch_take && (jump_mode == 2'b11);

    // Offset is already D bits wide, so modulo-2^D add is the sign extension.
    always_comb begin
        next_pc   = pc_inc;
        push_ok   = 1'b0;
        pop_ok    = 1'b0;
        ras_fault = 1'b0;
        unique case (1'b1)
            take_rel: next_pc = prog_counter + offset_target;
            take_abs: begin
                next_pc = entry_target;
                if (call_en) begin
                    if (ras_full) ras_fault = 1'b1;
                    else          push_ok   = 1'b1;
                end
            end
            take_ret: begin
                if (ras_empty) begin
                    ras_fault = 1'b1;
                end else begin
                    next_pc = ras[top_idx];
                    pop_ok  = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef PC_BOUNDS_CHECK_EN
    logic oob_hit;

    assign oob_hit = (32'(next_pc) >= $unsigned(PROG_LEN));
    assign pc_load = oob_hit ? START : next_pc;

    always_ff @(posedge Clk) begin
        if (!Reset)      pc_oob <= 1'b0;
        else if (!stall) pc_oob <= oob_hit;
        else             pc_oob <= 1'b0;
    end
`else
    assign pc_load = next_pc;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            prog_counter <= START;
            ras_count    <= '0;
            ras_err      <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
        end else if (!stall) begin
            prog_counter <= pc_load;
            if (push_ok) begin
                ras[push_idx] <= pc_inc;
                ras_count     <= ras_count + CW'(1);
            end else if (pop_ok) begin
                ras_count <= top_cnt;
            end
            if (ras_fault) ras_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_target_unit.sv
// Scoreboard bench for pc_target_unit: a reference model queues expected
// state per driven cycle, which is popped and compared after the edge.
module tb_pc_target_unit;

    localparam int D  = 12;
    localparam int RD = 4;
    localparam logic [D-1:0] ST = 12'd5;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          stall = 1'b0;
    logic [1:0]    jump_mode = 2'b00;
    logic          branch_take = 1'b0;
    logic [D-1:0]  offset_target = '0;
    logic [D-1:0]  entry_target = '0;
    logic          call_en = 1'b0;
    logic [D-1:0]  prog_counter;
    logic          ras_empty;
    logic          ras_full;
    logic [2:0]    ras_count;
    logic          ras_err;

    pc_target_unit #(.D(D), .RAS_DEPTH(RD), .START(ST), .PROG_LEN(4096)) dut (
        .Clk(Clk), .Reset(Reset), .stall(stall), .jump_mode(jump_mode),
        .branch_take(branch_take), .offset_target(offset_target),
        .entry_target(entry_target), .call_en(call_en),
        .prog_counter(prog_counter), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_count(ras_count), .ras_err(ras_err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [D-1:0] pc;
        logic [2:0]   cnt;
        logic         err;
    } exp_t;

    exp_t         sb [$];
    logic [D-1:0] m_pc;
    logic [D-1:0] m_ras [RD];
    int           m_cnt;
    logic         m_err;
    int           n_chk = 0;
    int           n_fail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic rst, input logic stl, input logic [1:0] md,
                         input logic bt, input logic [D-1:0] off,
                         input logic [D-1:0] ent, input logic ce);
        logic [D-1:0] nxt;
        if (!rst) begin
            m_pc = ST; m_cnt = 0; m_err = 1'b0;
            for (int i = 0; i < RD; i++) m_ras[i] = '0;
        end else if (!stl) begin
            nxt = m_pc + 12'd1;
            if (bt) begin
                case (md)
                    2'b01: nxt = m_pc + off;
                    2'b10: begin
                        nxt = ent;
                        if (ce) begin
                            if (m_cnt < RD) begin
                                m_ras[m_cnt] = m_pc + 12'd1;
                                m_cnt++;
                            end else m_err = 1'b1;
                        end
                    end
                    2'b11: begin
                        if (m_cnt > 0) begin
                            m_cnt--;
                            nxt = m_ras[m_cnt];
                        end else m_err = 1'b1;
                    end
                    default: ;
                endcase
            end
            m_pc = nxt;
        end
    endtask

    task automatic step(input logic rst, input logic stl, input logic [1:0] md,
                        input logic bt, input logic [D-1:0] off,
                        input logic [D-1:0] ent, input logic ce);
        exp_t e;
        Reset = rst; stall = stl; jump_mode = md; branch_take = bt;
        offset_target = off; entry_target = ent; call_en = ce;
        model(rst, stl, md, bt, off, ent, ce);
        sb.push_back('{pc: m_pc, cnt: 3'(m_cnt), err: m_err});
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underrun", 0, 1);
        end else begin
            e = sb.pop_front();
            check("pc", int'(prog_counter), int'(e.pc));
            check("cnt", int'(ras_count), int'(e.cnt));
            check("err", int'(ras_err), int'(e.err));
            check("empty", int'(ras_empty), int'(e.cnt == 0));
            check("full", int'(ras_full), int'(e.cnt == RD));
        end
    endtask

    task automatic seq();
        step(1, 0, 2'b00, 0, '0, '0, 0);
    endtask

    task automatic go(input logic [D-1:0] a);
        step(1, 0, 2'b10, 1, '0, a, 0);
    endtask

    initial begin
        @(negedge Clk);
        // 1: reset then sequential
        step(0, 0, 2'b00, 0, '0, '0, 0);
        step(0, 0, 2'b00, 0, '0, '0, 0);
        check("t1_reset_pc", int'(prog_counter), 5);
        seq(); check("t1_pc6", int'(prog_counter), 6);
        seq(); check("t1_pc7", int'(prog_counter), 7);
        seq(); check("t1_pc8", int'(prog_counter), 8);
        check("t1_empty", int'(ras_empty), 1);

        // 2: relative taken / not taken
        go(12'd10);
        step(1, 0, 2'b01, 1, 12'hFFB, '0, 0);
        check("t2_rel_taken", int'(prog_counter), 5);
        go(12'd10);
        step(1, 0, 2'b01, 0, 12'hFFB, '0, 0);
        check("t2_rel_not", int'(prog_counter), 11);

        // 3: call and return
        go(12'd20);
        step(1, 0, 2'b10, 1, '0, 12'd100, 1);
        check("t3_call_pc", int'(prog_counter), 100);
        check("t3_call_cnt", int'(ras_count), 1);
        step(1, 0, 2'b11, 1, '0, '0, 0);
        check("t3_ret_pc", int'(prog_counter), 21);
        check("t3_ret_empty", int'(ras_empty), 1);

        // 4: overflow then LIFO returns
        go(12'd200);
        for (int i = 1; i <= 5; i++) step(1, 0, 2'b10, 1, '0, 12'(200 + 100 * i), 1);
        check("t4_ovf_pc", int'(prog_counter), 700);
        check("t4_ovf_err", int'(ras_err), 1);
        check("t4_ovf_cnt", int'(ras_count), 4);
        step(1, 0, 2'b11, 1, '0, '0, 0); check("t4_ret1", int'(prog_counter), 501);
        step(1, 0, 2'b11, 1, '0, '0, 0); check("t4_ret2", int'(prog_counter), 401);
        step(1, 0, 2'b11, 1, '0, '0, 0); check("t4_ret3", int'(prog_counter), 301);
        step(1, 0, 2'b11, 1, '0, '0, 0); check("t4_ret4", int'(prog_counter), 201);
        step(0, 0, 2'b00, 0, '0, '0, 0);

        // 5: underflow and sticky error
        go(12'd30);
        step(1, 0, 2'b11, 1, '0, '0, 0);
        check("t5_unf_pc", int'(prog_counter), 31);
        check("t5_unf_err", int'(ras_err), 1);
        for (int i = 0; i < 10; i++) seq();
        check("t5_sticky", int'(ras_err), 1);
        step(0, 0, 2'b00, 0, '0, '0, 0);
        check("t5_clear", int'(ras_err), 0);

        // 6: stall, wrap, reset over stall
        go(12'd40);
        for (int i = 0; i < 3; i++) step(1, 1, 2'b10, 1, '0, 12'd300, 1);
        check("t6_stall_pc", int'(prog_counter), 40);
        check("t6_stall_cnt", int'(ras_count), 0);
        go(12'hFFF);
        seq();
        check("t6_wrap", int'(prog_counter), 0);
        step(1, 0, 2'b10, 1, '0, 12'd77, 1);
        step(0, 1, 2'b11, 1, '0, '0, 0);
        check("t6_rst_stall_pc", int'(prog_counter), 5);
        check("t6_rst_stall_cnt", int'(ras_count), 0);

        // mixed traffic against the model
        for (int i = 0; i < 200; i++)
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 5) == 0),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                 12'($urandom), 12'($urandom), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
